// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath; beq 3, ALU/sd 4, ld 5 cycles.
// FETCH stretches on im_ready and MEM on dm_ready; traps on illegal encodings or DM timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] instr,
  input  logic        Zero_Flag,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        imReq,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        AluSrc,
  output logic [3:0]  AluControl,
  output logic        Branch,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        memtoReg,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LD, C_SD, C_BEQ
  } cls_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, dec_cls;
  logic       src_q, src_d, dec_src;
  logic [3:0] alu_q, alu_d, dec_alu;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_zero;

  assign {funct7, funct3, opcode} = instr;
  // Zero_Flag is consumed by the datapath's PC mux, not by the sequencer.
  assign unused_zero = Zero_Flag;

  always_comb begin
    dec_cls = C_NONE;
    dec_src = 1'b0;
    dec_alu = ALU_AND;
    case (opcode)
      7'b0110011: begin
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_cls = C_R;
              dec_alu = ALU_ADD;
            end else if (funct7 == 7'b0100000) begin
              dec_cls = C_R;
              dec_alu = ALU_SUB;
            end
          end
          3'b111: if (funct7 == 7'b0000000) begin
            dec_cls = C_R;
            dec_alu = ALU_AND;
          end
          3'b110: if (funct7 == 7'b0000000) begin
            dec_cls = C_R;
            dec_alu = ALU_OR;
          end
          default: dec_cls = C_NONE;
        endcase
      end
      7'b0010011: begin
        dec_src = 1'b1;
        case (funct3)
          3'b000: begin
            dec_cls = C_I;
            dec_alu = ALU_ADD;
          end
          3'b111: begin
            dec_cls = C_I;
            dec_alu = ALU_AND;
          end
          3'b110: begin
            dec_cls = C_I;
            dec_alu = ALU_OR;
          end
          default: dec_cls = C_NONE;
        endcase
      end
      7'b0000011: if (funct3 == 3'b011) begin
        dec_cls = C_LD;
        dec_src = 1'b1;
        dec_alu = ALU_ADD;
      end
      7'b0100011: if (funct3 == 3'b011) begin
        dec_cls = C_SD;
        dec_src = 1'b1;
        dec_alu = ALU_ADD;
      end
      7'b1100011: if (funct3 == 3'b000) begin
        dec_cls = C_BEQ;
        dec_alu = ALU_SUB;
      end
      default: dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    src_d      = src_q;
    alu_d      = alu_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    imReq      = 1'b0;
    pcWrite    = 1'b0;
    AluSrc     = 1'b0;
    AluControl = ALU_AND;
    Branch     = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    memtoReg   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imReq = 1'b1;
        if (im_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_cls != C_NONE) begin
          cls_d   = dec_cls;
          src_d   = dec_src;
          alu_d   = dec_alu;
          state_d = S_EXEC;
        end else begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        AluSrc     = src_q;
        AluControl = alu_q;
        cnt_d      = 8'd0;
        case (cls_q)
          C_BEQ: begin
            Branch  = 1'b1;
            pcWrite = 1'b1;
            state_d = S_FETCH;
          end
          C_LD, C_SD: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        AluSrc     = 1'b1;
        AluControl = ALU_ADD;
        memRead    = (cls_q == C_LD);
        memWrite   = (cls_q == C_SD);
        // A completing handshake wins over a timeout landing on the same cycle.
        if (dm_ready) begin
          if (cls_q == C_SD) begin
            pcWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TO_LAST) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        memtoReg = (cls_q == C_LD);
        state_d  = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Gated by reset so no IR load can slip through while reset is held.
  assign irWrite    = imReq & im_ready & ~reset;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state_o    = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      src_q   <= 1'b0;
      alu_q   <= 4'b0000;
      cnt_q   <= 8'd0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      src_q   <= src_d;
      alu_q   <= alu_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with TIMEOUT=4; control outputs are checked as one packed word per cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] instr;
  logic        Zero_Flag;
  logic        im_ready;
  logic        dm_ready;
  logic        imReq, irWrite, pcWrite, AluSrc, Branch;
  logic        memRead, memWrite, regWrite, memtoReg, trap;
  logic [3:0]  AluControl;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .Zero_Flag  (Zero_Flag),
    .im_ready   (im_ready),
    .dm_ready   (dm_ready),
    .imReq      (imReq),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .AluSrc     (AluSrc),
    .AluControl (AluControl),
    .Branch     (Branch),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .regWrite   (regWrite),
    .memtoReg   (memtoReg),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // {imReq, irWrite, pcWrite, AluSrc, AluControl[3:0], Branch, memRead, memWrite, regWrite, memtoReg}
  logic [12:0] ctl;
  assign ctl = {imReq, irWrite, pcWrite, AluSrc, AluControl, Branch,
                memRead, memWrite, regWrite, memtoReg};

  localparam logic [12:0] K_NONE    = 13'b0_0_0_0_0000_0_0_0_0_0;
  localparam logic [12:0] K_F_IDLE  = 13'b1_0_0_0_0000_0_0_0_0_0;
  localparam logic [12:0] K_F_RDY   = 13'b1_1_0_0_0000_0_0_0_0_0;
  localparam logic [12:0] K_EX_ADD  = 13'b0_0_0_0_0010_0_0_0_0_0;
  localparam logic [12:0] K_EX_SUB  = 13'b0_0_0_0_0110_0_0_0_0_0;
  localparam logic [12:0] K_EX_ORI  = 13'b0_0_0_1_0001_0_0_0_0_0;
  localparam logic [12:0] K_EX_MEM  = 13'b0_0_0_1_0010_0_0_0_0_0;
  localparam logic [12:0] K_EX_BEQ  = 13'b0_0_1_0_0110_1_0_0_0_0;
  localparam logic [12:0] K_M_LD    = 13'b0_0_0_1_0010_0_1_0_0_0;
  localparam logic [12:0] K_M_SD    = 13'b0_0_0_1_0010_0_0_1_0_0;
  localparam logic [12:0] K_M_SD_OK = 13'b0_0_1_1_0010_0_0_1_0_0;
  localparam logic [12:0] K_WB_R    = 13'b0_0_1_0_0000_0_0_0_1_0;
  localparam logic [12:0] K_WB_LD   = 13'b0_0_1_0_0000_0_0_0_1_1;

  localparam logic [16:0] I_ADD = {7'b0000000, 3'b000, 7'b0110011};
  localparam logic [16:0] I_SUB = {7'b0100000, 3'b000, 7'b0110011};
  localparam logic [16:0] I_ORI = {7'b1111111, 3'b110, 7'b0010011};
  localparam logic [16:0] I_LD  = {7'b0000000, 3'b011, 7'b0000011};
  localparam logic [16:0] I_SD  = {7'b0000000, 3'b011, 7'b0100011};
  localparam logic [16:0] I_BEQ = {7'b0000000, 3'b000, 7'b1100011};
  localparam logic [16:0] I_ILL = {7'b0000000, 3'b000, 7'b1111111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; checks this cycle's state and controls, then moves to the next posedge+1.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] c);
    #1;
    check({tag, "_st"}, {29'd0, state_o}, {29'd0, st});
    check({tag, "_ctl"}, {19'd0, ctl}, {19'd0, c});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b1;
    im_ready = 1'b1;
    #1;
    check({tag, "_st"}, {29'd0, state_o}, 32'd0);
    check({tag, "_ctl"}, {19'd0, ctl}, {19'd0, K_F_IDLE});
    check({tag, "_trap"}, {31'd0, trap}, 32'd0);
    check({tag, "_cause"}, {30'd0, trap_cause}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    im_ready = 1'b0;
    dm_ready = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [16:0] ins, input logic [12:0] ex);
    instr    = ins;
    im_ready = 1'b1;
    cyc({tag, "_f"}, 3'd0, K_F_RDY);
    im_ready = 1'b0;
    cyc({tag, "_d"}, 3'd1, K_NONE);
    cyc({tag, "_e"}, 3'd2, ex);
    cyc({tag, "_w"}, 3'd4, K_WB_R);
  endtask

  initial begin
    reset     = 1'b1;
    instr     = '0;
    Zero_Flag = 1'b0;
    im_ready  = 1'b1;
    dm_ready  = 1'b0;
    #2;
    check("rst_st", {29'd0, state_o}, 32'd0);
    check("rst_ctl", {19'd0, ctl}, {19'd0, K_F_IDLE});
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_cause", {30'd0, trap_cause}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    im_ready = 1'b0;

    run_alu("add", I_ADD, K_EX_ADD);
    cyc("fstall", 3'd0, K_F_IDLE);
    run_alu("sub", I_SUB, K_EX_SUB);
    run_alu("ori", I_ORI, K_EX_ORI);

    // ld with three wait states; ready lands on the last counter value
    instr = I_LD; im_ready = 1'b1;
    cyc("ld_f", 3'd0, K_F_RDY);
    im_ready = 1'b0;
    cyc("ld_d", 3'd1, K_NONE);
    cyc("ld_e", 3'd2, K_EX_MEM);
    for (int i = 0; i < 3; i++) cyc("ld_mw", 3'd3, K_M_LD);
    dm_ready = 1'b1;
    cyc("ld_m", 3'd3, K_M_LD);
    dm_ready = 1'b0;
    cyc("ld_w", 3'd4, K_WB_LD);

    instr = I_SD; im_ready = 1'b1; dm_ready = 1'b1;
    cyc("sd_f", 3'd0, K_F_RDY);
    im_ready = 1'b0;
    cyc("sd_d", 3'd1, K_NONE);
    cyc("sd_e", 3'd2, K_EX_MEM);
    cyc("sd_m", 3'd3, K_M_SD_OK);
    dm_ready = 1'b0;

    instr = I_BEQ; im_ready = 1'b1;
    cyc("beq_f", 3'd0, K_F_RDY);
    im_ready = 1'b0;
    cyc("beq_d", 3'd1, K_NONE);
    cyc("beq_e", 3'd2, K_EX_BEQ);

    instr = I_SD; im_ready = 1'b1;
    cyc("sd4_f", 3'd0, K_F_RDY);
    im_ready = 1'b0;
    cyc("sd4_d", 3'd1, K_NONE);
    cyc("sd4_e", 3'd2, K_EX_MEM);
    for (int i = 0; i < 3; i++) cyc("sd4_mw", 3'd3, K_M_SD);
    dm_ready = 1'b1;
    cyc("sd4_m", 3'd3, K_M_SD_OK);
    dm_ready = 1'b0;

    instr = I_SD; im_ready = 1'b1;
    cyc("to_f", 3'd0, K_F_RDY);
    im_ready = 1'b0;
    cyc("to_d", 3'd1, K_NONE);
    cyc("to_e", 3'd2, K_EX_MEM);
    for (int i = 0; i < 4; i++) cyc("to_mw", 3'd3, K_M_SD);
    cyc("to_trap", 3'd7, K_NONE);
    check("to_trapflag", {31'd0, trap}, 32'd1);
    check("to_cause", {30'd0, trap_cause}, 32'd2);
    do_reset("rst2");

    instr = I_ILL; im_ready = 1'b1;
    cyc("ill_f", 3'd0, K_F_RDY);
    cyc("ill_d", 3'd1, K_NONE);
    dm_ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc("ill_hold", 3'd7, K_NONE);
    check("ill_trapflag", {31'd0, trap}, 32'd1);
    check("ill_cause", {30'd0, trap_cause}, 32'd1);
    do_reset("rst3");

    instr = I_LD; im_ready = 1'b1;
    cyc("ar_f", 3'd0, K_F_RDY);
    im_ready = 1'b0;
    cyc("ar_d", 3'd1, K_NONE);
    cyc("ar_e", 3'd2, K_EX_MEM);
    cyc("ar_m", 3'd3, K_M_LD);
    #3;
    reset = 1'b1;
    #1;
    check("ar_memrd", {31'd0, memRead}, 32'd0);
    check("ar_st", {29'd0, state_o}, 32'd0);
    check("ar_ctl", {19'd0, ctl}, {19'd0, K_F_IDLE});
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_alu("post", I_ADD, K_EX_ADD);
    cyc("post_f", 3'd0, K_F_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 64-bit RISC-V datapath. It decodes the 17-bit `instr` field that the datapath exports as {funct7, funct3, opcode} and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. In each step it drives the datapath control inputs plus PC/IR write enables. It stretches FETCH and MEM on instruction- and data-memory ready handshakes, and traps on illegal opcodes or data-memory timeout.

## Interface
- `TIMEOUT`, 16: maximum cycles MEM waits for `dm_ready` before trapping (range 1..255).
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; forces state FETCH and clears all registers.
- `instr` in 17: {funct7[6:0], funct3[2:0], opcode[6:0]} from the datapath.
- `Zero_Flag` in 1: ALU zero; observed only in EXEC of `beq`, and only by the datapath.
- `im_ready` in 1: instruction memory has valid `IM_readData` this cycle.
- `dm_ready` in 1: data memory has completed the current read or write this cycle.
- `imReq` out 1: instruction fetch request.
- `irWrite` out 1: latch instruction register.
- `pcWrite` out 1: update PC; the datapath selects the branch target when `Branch & Zero_Flag`.
- `AluSrc` out 1: 0 selects register operand B; 1 selects immediate.
- `AluControl` out 4: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- `Branch` out 1: branch qualifier.
- `memRead` out 1: data memory read.
- `memWrite` out 1: data memory write.
- `regWrite` out 1: register file write.
- `memtoReg` out 1: writeback source; 1 selects `DM_readData`.
- `trap` out 1: sticky error flag.
- `trap_cause` out 2: 00 none, 01 illegal instruction, 10 DM timeout.
- `state_o` out 3: current state, for debug.

## Operation
- Supported instructions, with `AluSrc` / `AluControl`:
  - R-type, opcode 0110011: add (f3 000, f7 0000000) 0/ADD; sub (f3 000, f7 0100000) 0/SUB; and (f3 111) 0/AND; or (f3 110) 0/OR.
  - I-type, opcode 0010011: addi (f3 000) 1/ADD; andi (f3 111) 1/AND; ori (f3 110) 1/OR.
  - ld, opcode 0000011, f3 011: 1/ADD.
  - sd, opcode 0100011, f3 011: 1/ADD.
  - beq, opcode 1100011, f3 000: 0/SUB.
- Any other encoding is illegal. For I-type, ld, sd and beq, funct7 is ignored.
- State encoding on `state_o`: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH: `imReq`=1. When `im_ready`=1, `irWrite`=1 in the same cycle and next state is DECODE; otherwise stay.
- DECODE: decode `instr` into an internal class/ALU register.
  - Legal instruction: next state is EXEC.
  - Illegal instruction: next state is TRAP, with cause 01.
- EXEC: drive `AluSrc`/`AluControl` from the decode register.
  - beq: `Branch`=1 and `pcWrite`=1, then FETCH.
  - R-type and I-type: go to WB.
  - ld and sd: go to MEM.
- MEM: hold `AluSrc`=1 and `AluControl`=ADD. `memRead` (ld) or `memWrite` (sd) is held continuously until `dm_ready`=1.
  - On `dm_ready`: sd asserts `pcWrite`=1 and goes to FETCH; ld goes to WB.
  - Wait counter: cleared on MEM entry, incremented each MEM cycle with `dm_ready`=0.
  - Timeout: if `dm_ready`=0 on the cycle the counter reaches `TIMEOUT`-1, go to TRAP with cause 10. The memory strobe drops on TRAP entry.
  - `dm_ready` takes priority over timeout in the same cycle.
- WB: `regWrite`=1 and `pcWrite`=1; `memtoReg`=1 only for ld. Next state is FETCH.
- TRAP: all control outputs 0 and `trap`=1; `trap_cause` holds. Only `reset` exits TRAP.
- Output rules:
  - All control outputs are pure functions of the state register and the decode register (Moore), except `irWrite`, which is `imReq & im_ready`.
  - Outputs not listed for a state are 0.
- `im_ready` and `dm_ready` are ignored outside FETCH and MEM respectively.

## Timing
- Reset values: state FETCH, decode register cleared, wait counter 0, `trap`=0, `trap_cause`=00.
  - During reset `imReq`=1; every other output is 0, including `irWrite`, which is gated by `reset`.
- Latency with zero wait states, fetch to next fetch:
  - beq: 3 cycles.
  - R-type, I-type, sd: 4 cycles.
  - ld: 5 cycles.
- Each FETCH cycle with `im_ready`=0 adds one cycle. Each MEM cycle with `dm_ready`=0 adds one cycle.
- `pcWrite` is asserted exactly once per retired instruction and never in TRAP.
- Reset asserted mid-instruction, in any state: outputs go to reset values immediately, without waiting for a clock edge. No partial `regWrite` or `memWrite` follows.
- Timeout boundary, `TIMEOUT`=16: with `dm_ready` low for 16 consecutive MEM cycles, TRAP is entered on the following edge. Ready on the 16th MEM cycle completes normally.

## Test plan
- **Reset and add:** reset, then `im_ready`=1, `instr`={0000000,000,0110011}.
  - `state_o` sequence 0,1,2,4,0.
  - `irWrite` in cycle 0; `AluControl`=0010 and `AluSrc`=0 in EXEC; `regWrite`=`pcWrite`=1 in WB only.
- **ld with wait states:** f3 011, opcode 0000011; `dm_ready` low for 3 MEM cycles, then high.
  - `memRead`=1 for 4 cycles.
  - WB with `memtoReg`=1; total 8 cycles fetch to fetch.
- **sd and beq:**
  - sd with `dm_ready`=1: `memWrite` for 1 cycle, `pcWrite` in MEM, never `regWrite`.
  - beq: `Branch`=`pcWrite`=1 in EXEC with `AluControl`=0110, 3 cycles total.
- **Illegal opcode:** `instr`={0000000,000,1111111}.
  - TRAP after DECODE with `trap`=1 and `trap_cause`=01.
  - All controls stay 0 for 20 cycles despite `im_ready`=1.
- **DM timeout:** `TIMEOUT`=4, sd with `dm_ready`=0.
  - `memWrite` for exactly 4 cycles, then `trap_cause`=10.
  - Repeat with `dm_ready`=1 on the 4th cycle: completes normally.
- **Async reset mid-MEM:** assert `reset` between clock edges during a ld wait.
  - `memRead` drops immediately and `state_o`=0.
  - After deassert, normal fetch resumes.
